// File: rtl/jogo_memoria_param_pkg.sv
// Shared definitions for the sequence-memory game family: state codes and small helpers.
package jogo_memoria_param_pkg;

   typedef enum logic [3:0] {
      INICIAL     = 4'h0,
      PREPARA     = 4'h1,
      MOSTRA      = 4'h2,
      ESPERA      = 4'h3,
      REGISTRA    = 4'h4,
      COMPARA     = 4'h5,
      PROXIMA     = 4'h6,
      NOVA_RODADA = 4'h7,
      FIM_ACERTO  = 4'hA,
      FIM_ERRO    = 4'hE,
      FIM_TIMEOUT = 4'hF
   } estado_t;

   function automatic int largura(input int valor);
      return (valor > 1) ? $clog2(valor) : 1;
   endfunction

   // Default sequence: entry k lights button (k mod n_botoes).
   function automatic int indice_botao(input int k, input int n_botoes);
      return k % n_botoes;
   endfunction

endpackage

// File: rtl/memoria_sequencia.sv
// Combinational ROM holding the expected move for each sequence position (one-hot words).
module memoria_sequencia
   import jogo_memoria_param_pkg::*;
#(
   parameter int  N_BOTOES    = 4,
   parameter int  NUM_RODADAS = 16,
   localparam int CW          = $clog2(NUM_RODADAS)
) (
   input  logic [CW-1:0]       i_endereco,
   output logic [N_BOTOES-1:0] o_jogada
);

   always_comb begin
      o_jogada = '0;
      for (int b = 0; b < N_BOTOES; b++) begin
         if (indice_botao(int'(i_endereco), N_BOTOES) == b) o_jogada[b] = 1'b1;
      end
   end

endmodule

// File: rtl/jogo_memoria_param.sv
// Sequence-memory game core: shows a growing one-hot sequence on the LEDs and checks the
// player's moves against it, ending on win, wrong move or inactivity.
//
//   state        | meaning
//   INICIAL      | idle after reset, waiting for jogar
//   PREPARA      | round setup, chooses show or skip
//   MOSTRA       | replaying moves 0..rodada, on/off slot per move
//   ESPERA       | waiting for a button press, inactivity timer running
//   REGISTRA     | captured move settles
//   COMPARA      | captured move checked against the sequence
//   PROXIMA      | advance to next move of this round
//   NOVA_RODADA  | advance to next round
//   FIM_*        | game over (win / error / timeout), held until jogar
module jogo_memoria_param
   import jogo_memoria_param_pkg::*;
#(
   parameter int  N_BOTOES       = 4,
   parameter int  NUM_RODADAS    = 16,
   parameter int  TIMEOUT_CICLOS = 3000,
   parameter int  T_MOSTRA       = 500,
   localparam int CW             = $clog2(NUM_RODADAS)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                jogar,
   input  logic                modo,
   input  logic [N_BOTOES-1:0] botoes,
   output logic [N_BOTOES-1:0] leds,
   output logic                acertou,
   output logic                errou,
   output logic                timeout,
   output logic                pronto,
   output logic [3:0]          db_estado,
   output logic [CW-1:0]       db_rodada,
   output logic [CW-1:0]       db_contagem,
   output logic [N_BOTOES-1:0] db_jogada
);

   localparam int T_MAX = (TIMEOUT_CICLOS > T_MOSTRA) ? TIMEOUT_CICLOS : T_MOSTRA;
   localparam int TW    = largura(T_MAX);

   estado_t             r_estado;
   logic                r_modo;
   logic [CW-1:0]       r_rodada;
   logic [CW-1:0]       r_contagem;
   logic [TW-1:0]       r_timer;
   logic                r_fase;
   logic [N_BOTOES-1:0] r_botoes_q;
   logic [N_BOTOES-1:0] r_jogada;
   logic [N_BOTOES-1:0] r_leds;
   logic                r_acertou;
   logic                r_errou;
   logic                r_timeout;
   logic                r_pronto;

   logic                w_press;
   logic                w_fim_slot;
   logic                w_fim_espera;
   logic [CW-1:0]       w_endereco;
   logic [N_BOTOES-1:0] w_esperada;

   assign w_press      = (|botoes) & ~(|r_botoes_q);
   assign w_fim_slot   = (r_timer == TW'(T_MOSTRA - 1));
   assign w_fim_espera = (r_timer == TW'(TIMEOUT_CICLOS - 1));

   // At the end of an off slot the LED register loads the next move, so look one ahead.
   assign w_endereco = (r_estado == MOSTRA && r_fase && w_fim_slot) ?
                       r_contagem + CW'(1) : r_contagem;

   memoria_sequencia #(
      .N_BOTOES    (N_BOTOES),
      .NUM_RODADAS (NUM_RODADAS)
   ) u_memoria (
      .i_endereco (w_endereco),
      .o_jogada   (w_esperada)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_estado   <= INICIAL;
         r_modo     <= 1'b0;
         r_rodada   <= '0;
         r_contagem <= '0;
         r_timer    <= '0;
         r_fase     <= 1'b0;
         r_botoes_q <= '0;
         r_jogada   <= '0;
         r_leds     <= '0;
         r_acertou  <= 1'b0;
         r_errou    <= 1'b0;
         r_timeout  <= 1'b0;
         r_pronto   <= 1'b0;
      end else begin
         r_botoes_q <= botoes;
         case (r_estado)
            INICIAL, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
               if (jogar) begin
                  r_modo     <= modo;
                  r_rodada   <= '0;
                  r_contagem <= '0;
                  r_jogada   <= '0;
                  r_timer    <= '0;
                  r_fase     <= 1'b0;
                  r_leds     <= '0;
                  r_acertou  <= 1'b0;
                  r_errou    <= 1'b0;
                  r_timeout  <= 1'b0;
                  r_pronto   <= 1'b0;
                  r_estado   <= PREPARA;
               end
            end

            PREPARA: begin
               r_contagem <= '0;
               r_timer    <= '0;
               r_fase     <= 1'b0;
               if (!r_modo) begin
                  r_leds   <= w_esperada;
                  r_estado <= MOSTRA;
               end else begin
                  r_estado <= ESPERA;
               end
            end

            MOSTRA: begin
               if (w_fim_slot) begin
                  r_timer <= '0;
                  if (!r_fase) begin
                     r_fase <= 1'b1;
                     r_leds <= '0;
                  end else if (r_contagem == r_rodada) begin
                     r_fase     <= 1'b0;
                     r_contagem <= '0;
                     r_leds     <= '0;
                     r_estado   <= ESPERA;
                  end else begin
                     r_fase     <= 1'b0;
                     r_contagem <= r_contagem + CW'(1);
                     r_leds     <= w_esperada;
                  end
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end

            // A press on the terminal-count edge still counts as a move.
            ESPERA: begin
               if (w_press) begin
                  r_jogada <= botoes;
                  r_estado <= REGISTRA;
               end else if (w_fim_espera) begin
                  r_timeout <= 1'b1;
                  r_pronto  <= 1'b1;
                  r_estado  <= FIM_TIMEOUT;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end

            REGISTRA: begin
               r_estado <= COMPARA;
            end

            COMPARA: begin
               if (r_jogada != w_esperada) begin
                  r_errou  <= 1'b1;
                  r_pronto <= 1'b1;
                  r_estado <= FIM_ERRO;
               end else if (r_contagem == r_rodada) begin
                  if (r_rodada == CW'(NUM_RODADAS - 1)) begin
                     r_acertou <= 1'b1;
                     r_pronto  <= 1'b1;
                     r_estado  <= FIM_ACERTO;
                  end else begin
                     r_estado <= NOVA_RODADA;
                  end
               end else begin
                  r_estado <= PROXIMA;
               end
            end

            PROXIMA: begin
               r_contagem <= r_contagem + CW'(1);
               r_timer    <= '0;
               r_estado   <= ESPERA;
            end

            NOVA_RODADA: begin
               r_rodada   <= r_rodada + CW'(1);
               r_contagem <= '0;
               r_estado   <= PREPARA;
            end

            default: begin
               r_leds    <= '0;
               r_acertou <= 1'b0;
               r_errou   <= 1'b0;
               r_timeout <= 1'b0;
               r_pronto  <= 1'b0;
               r_estado  <= INICIAL;
            end
         endcase
      end
   end

   assign leds        = r_leds;
   assign acertou     = r_acertou;
   assign errou       = r_errou;
   assign timeout     = r_timeout;
   assign pronto      = r_pronto;
   assign db_estado   = r_estado;
   assign db_rodada   = r_rodada;
   assign db_contagem = r_contagem;
   assign db_jogada   = r_jogada;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Randomized self-checking bench for the sequence-memory game against a round-level model.
module tb_jogo_memoria_param;

   localparam int NB = 4;
   localparam int NR = 4;
   localparam int TO = 20;
   localparam int TM = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          jogar;
   logic          modo;
   logic [NB-1:0] botoes;
   logic [NB-1:0] leds;
   logic          acertou;
   logic          errou;
   logic          timeout;
   logic          pronto;
   logic [3:0]    db_estado;
   logic [1:0]    db_rodada;
   logic [1:0]    db_contagem;
   logic [NB-1:0] db_jogada;

   int n_checks = 0;
   int n_fail   = 0;

   jogo_memoria_param #(
      .N_BOTOES       (NB),
      .NUM_RODADAS    (NR),
      .TIMEOUT_CICLOS (TO),
      .T_MOSTRA       (TM)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .jogar       (jogar),
      .modo        (modo),
      .botoes      (botoes),
      .leds        (leds),
      .acertou     (acertou),
      .errou       (errou),
      .timeout     (timeout),
      .pronto      (pronto),
      .db_estado   (db_estado),
      .db_rodada   (db_rodada),
      .db_contagem (db_contagem),
      .db_jogada   (db_jogada)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected move i of the game sequence.
   function automatic logic [NB-1:0] seq_esp(input int i);
      return NB'(1) << (i % NB);
   endfunction

   function automatic logic [NB-1:0] jogada_errada(input logic [NB-1:0] certa);
      logic [NB-1:0] v;
      do v = NB'($urandom_range(1, (1 << NB) - 1)); while (v == certa);
      return v;
   endfunction

   task automatic check_zero(input string tag);
      check_eq({tag, "_leds"},     leds,        0);
      check_eq({tag, "_acertou"},  acertou,     0);
      check_eq({tag, "_errou"},    errou,       0);
      check_eq({tag, "_timeout"},  timeout,     0);
      check_eq({tag, "_pronto"},   pronto,      0);
      check_eq({tag, "_estado"},   db_estado,   0);
      check_eq({tag, "_rodada"},   db_rodada,   0);
      check_eq({tag, "_contagem"}, db_contagem, 0);
      check_eq({tag, "_jogada"},   db_jogada,   0);
   endtask

   task automatic check_fim(input logic [3:0] est, input int rod, input int cont,
                            input logic [NB-1:0] jog);
      check_eq("fim_estado",   db_estado,   est);
      check_eq("fim_acertou",  acertou,     est == 4'hA);
      check_eq("fim_errou",    errou,       est == 4'hE);
      check_eq("fim_timeout",  timeout,     est == 4'hF);
      check_eq("fim_pronto",   pronto,      1);
      check_eq("fim_rodada",   db_rodada,   rod);
      check_eq("fim_contagem", db_contagem, cont);
      check_eq("fim_jogada",   db_jogada,   jog);
      check_eq("fim_leds",     leds,        0);
   endtask

   // Show window of round k: (k+1) slots, each TM clocks on then TM clocks off.
   task automatic mostra_check(input int k);
      logic [NB-1:0] e;
      for (int j = 0; j < 2 * TM * (k + 1); j++) begin
         e = ((j % (2 * TM)) < TM) ? seq_esp(j / (2 * TM)) : '0;
         if (j == 0) check_eq("mostra_estado", db_estado, 4'h2);
         check_eq("mostra_leds", leds, e);
         jogar = 1'($urandom_range(0, 1));
         modo  = 1'($urandom_range(0, 1));
         @(negedge clock);
      end
      jogar = 1'b0;
   endtask

   // Hold a press for 5 clocks; lat = first cycle (1..5) pronto was seen, 0 if never.
   task automatic press(input logic [NB-1:0] v, output int lat);
      lat    = 0;
      jogar  = 1'b0;
      botoes = v;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clock);
         if (lat == 0 && pronto) lat = c;
         if (c < 5) check_eq("press_leds", leds, 0);
      end
      botoes = '0;
   endtask

   // One full game. er/ei: round/index of a wrong move (ev), tr: round whose first move times out.
   task automatic run_game(input logic m, input int er, input int ei, input logic [NB-1:0] ev,
                           input int tr);
      int            lat;
      int            g;
      bit            fim;
      logic [NB-1:0] v;
      logic [NB-1:0] ultima;
      jogar = 1'b1;
      modo  = m;
      @(negedge clock);
      check_eq("prep_estado",   db_estado,   4'h1);
      check_eq("prep_pronto",   pronto,      0);
      check_eq("prep_errou",    errou,       0);
      check_eq("prep_acertou",  acertou,     0);
      check_eq("prep_timeout",  timeout,     0);
      check_eq("prep_rodada",   db_rodada,   0);
      check_eq("prep_jogada",   db_jogada,   0);
      jogar = 1'b0;
      modo  = ~m;
      @(negedge clock);
      fim    = 1'b0;
      ultima = '0;
      for (int k = 0; k < NR && !fim; k++) begin
         if (!m) mostra_check(k);
         check_eq("espera_estado",   db_estado,   4'h3);
         check_eq("espera_rodada",   db_rodada,   k);
         check_eq("espera_contagem", db_contagem, 0);
         check_eq("espera_leds",     leds,        0);
         for (int i = 0; i <= k && !fim; i++) begin
            if (k == tr && i == 0) begin
               repeat (TO - 1) @(negedge clock);
               check_eq("pre_timeout_estado", db_estado, 4'h3);
               check_eq("pre_timeout_flag",   timeout,   0);
               @(negedge clock);
               check_fim(4'hF, k, 0, ultima);
               fim = 1'b1;
            end else begin
               g = (i == 0 && $urandom_range(0, 3) == 0) ? TO - 1 : $urandom_range(1, 4);
               repeat (g) begin
                  if (g < TO - 1) jogar = 1'($urandom_range(0, 1));
                  @(negedge clock);
               end
               v = (k == er && i == ei) ? ev : seq_esp(i);
               press(v, lat);
               ultima = v;
               if (v != seq_esp(i)) begin
                  check_eq("lat_erro", lat, 3);
                  check_fim(4'hE, k, i, v);
                  fim = 1'b1;
               end else if (i == k && k == NR - 1) begin
                  check_eq("lat_acerto", lat, 3);
                  check_fim(4'hA, k, i, v);
                  fim = 1'b1;
               end else begin
                  check_eq("lat_continua", lat, 0);
               end
            end
         end
      end
   endtask

   initial begin
      int            lat;
      int            er;
      int            ei;
      int            tr;
      logic          m;
      logic [NB-1:0] ev;

      reset  = 1'b1;
      jogar  = 1'b1;
      modo   = 1'b0;
      botoes = '0;
      repeat (2) @(negedge clock);
      check_zero("reset");
      reset = 1'b0;
      jogar = 1'b0;
      @(negedge clock);
      check_eq("idle_estado", db_estado, 4'h0);

      run_game(1'b0, -1, 0, '0, -1);
      run_game(1'b0, 2, 2, 4'b0010, -1);
      run_game(1'b0, -1, 0, '0, 1);
      run_game(1'b1, 0, 0, 4'b0011, -1);

      // Reset in the middle of round 1's show window.
      jogar = 1'b1;
      modo  = 1'b0;
      @(negedge clock);
      jogar = 1'b0;
      @(negedge clock);
      mostra_check(0);
      @(negedge clock);
      press(seq_esp(0), lat);
      check_eq("mid_rodada", db_rodada, 1);
      check_eq("mid_leds0",  leds,      seq_esp(0));
      repeat (3) @(negedge clock);
      check_eq("mid_leds3",  leds,      seq_esp(0));
      reset = 1'b1;
      jogar = 1'b1;
      @(negedge clock);
      check_zero("mid_reset");
      @(negedge clock);
      check_eq("reset_jogar_ignorado", db_estado, 4'h0);
      reset = 1'b0;
      jogar = 1'b0;
      @(negedge clock);

      // Button already held when ESPERA is entered must not count.
      jogar = 1'b1;
      modo  = 1'b1;
      @(negedge clock);
      jogar  = 1'b0;
      botoes = 4'b0001;
      @(negedge clock);
      check_eq("held_estado",  db_estado, 4'h3);
      check_eq("held_rodada",  db_rodada, 0);
      repeat (3) @(negedge clock);
      check_eq("held_ignored", db_estado, 4'h3);
      botoes = '0;
      @(negedge clock);
      botoes = 4'b0001;
      @(negedge clock);
      check_eq("repress_registra", db_estado, 4'h4);
      check_eq("repress_jogada",   db_jogada, 4'b0001);
      @(negedge clock);
      check_eq("repress_compara",  db_estado, 4'h5);
      botoes = '0;
      @(negedge clock);
      check_eq("repress_nova",     db_estado, 4'h7);
      repeat (2) @(negedge clock);
      check_eq("repress_espera",   db_estado, 4'h3);
      check_eq("repress_rodada",   db_rodada, 1);
      reset = 1'b1;
      @(negedge clock);
      check_zero("reset2");
      reset = 1'b0;
      @(negedge clock);

      for (int n = 0; n < 10; n++) begin
         m  = 1'($urandom_range(0, 1));
         er = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, NR - 1));
         ei = (er < 0) ? 0 : int'($urandom_range(0, er));
         ev = jogada_errada(seq_esp(ei));
         tr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NR - 1)) : -1;
         run_game(m, er, ei, ev, tr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, expected finish before %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
